add_sub_acc: RTL and testbench



---
 rtl/add_sub_acc_pkg.sv | 17 +
 rtl/add_sub_acc_add_sub.sv | 22 ++
 rtl/add_sub_acc.sv | 146 ++++++++++++++
 tb/tb_add_sub_acc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_acc_pkg.sv
// Shared definitions for the add_sub_acc accumulator slice:
// FSM state encoding, operation select codes and default widths.
package add_sub_acc_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub_acc_add_sub.sv
// Combinational add/subtract datapath. Subtract is A + ~B + 1, so cout=1 on
// subtract means no borrow (A >= B unsigned).
module add_sub
    import add_sub_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff       = (sel == OP_SUB) ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel};
    end

endmodule

// File: rtl/add_sub_acc.sv
// Accumulator register stage around add_sub: folds a handshaked operand stream
// into an accumulator and presents the batch result on a valid/ready port.
module add_sub_acc
    import add_sub_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_zero_q, out_zero_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             accept;
    logic             ovf;
    logic [CNT_W-1:0] count_inc;

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a    (acc_q),
        .b    (in_data),
        .sel  (in_sel),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready = (state_q != DONE) && !clr;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        ovf_sticky_d = ovf_sticky_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_carry_d  = out_carry_q;
        out_ovf_d    = out_ovf_q;
        out_zero_d   = out_zero_q;
        out_count_d  = out_count_q;

        // Signed overflow judged on the MSBs of acc, operand and sum
        if (in_sel == OP_SUB)
            ovf = (acc_q[WIDTH-1] != in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
        else
            ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);

        count_inc = (count_q == {CNT_W{1'b1}}) ? count_q
                                               : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

        case (state_q)
            IDLE, ACCUM: begin
                if (clr) begin
                    state_d      = IDLE;
                    acc_d        = '0;
                    count_d      = '0;
                    ovf_sticky_d = 1'b0;
                end else if (accept) begin
                    acc_d        = sum;
                    count_d      = count_inc;
                    ovf_sticky_d = ovf_sticky_q | ovf;
                    if (in_last) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = sum;
                        out_carry_d = cout;
                        out_ovf_d   = ovf_sticky_q | ovf;
                        out_zero_d  = (sum == '0);
                        out_count_d = count_inc;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                // Result fields keep their last values after the handoff
                if (out_valid_q && out_ready) begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b0;
                    acc_d        = '0;
                    count_d      = '0;
                    ovf_sticky_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_carry_q  <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_sticky_q <= ovf_sticky_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_carry_q  <= out_carry_d;
            out_ovf_q    <= out_ovf_d;
            out_zero_q   <= out_zero_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_add_sub_acc.sv
// Directed self-checking bench for add_sub_acc (WIDTH=4, CNT_W=4) with
// hand-computed expected results per scenario.
module tb_add_sub_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       in_sel = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic       out_carry;
    logic       out_ovf;
    logic       out_zero;
    logic [3:0] out_count;

    int checks = 0;
    int passed = 0;

    add_sub_acc #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Present one beat at the falling edge; returns #1 after the accepting rising edge
    task automatic send(input logic [3:0] data, input logic sel, input logic last);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_sel   = sel;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_data !== 4'h0) $display("[TB] FAIL reset_data: got %h want 0", out_data); else passed++;
        checks++; if (out_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d want 0", out_count); else passed++;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(4'd3, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL add_early_valid: got %b want 0", out_valid); else passed++;
        send(4'd5, 1'b0, 1'b0);
        send(4'd7, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL add_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 4'hF) $display("[TB] FAIL add_data: got %h want f", out_data); else passed++;
        checks++; if (out_carry !== 1'b0) $display("[TB] FAIL add_carry: got %b want 0", out_carry); else passed++;
        checks++; if (out_ovf !== 1'b1) $display("[TB] FAIL add_ovf: got %b want 1", out_ovf); else passed++;
        checks++; if (out_zero !== 1'b0) $display("[TB] FAIL add_zero: got %b want 0", out_zero); else passed++;
        checks++; if (out_count !== 4'd3) $display("[TB] FAIL add_count: got %0d want 3", out_count); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL add_handoff: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_wrap();
        send(4'd9, 1'b0, 1'b0);
        send(4'd9, 1'b0, 1'b1);
        checks++; if (out_data !== 4'h2) $display("[TB] FAIL wrap_data: got %h want 2", out_data); else passed++;
        checks++; if (out_carry !== 1'b1) $display("[TB] FAIL wrap_carry: got %b want 1", out_carry); else passed++;
        checks++; if (out_ovf !== 1'b1) $display("[TB] FAIL wrap_ovf: got %b want 1", out_ovf); else passed++;
        checks++; if (out_count !== 4'd2) $display("[TB] FAIL wrap_count: got %0d want 2", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        send(4'd5, 1'b0, 1'b0);
        send(4'd5, 1'b1, 1'b1);
        checks++; if (out_data !== 4'h0) $display("[TB] FAIL sub_zero_data: got %h want 0", out_data); else passed++;
        checks++; if (out_zero !== 1'b1) $display("[TB] FAIL sub_zero_flag: got %b want 1", out_zero); else passed++;
        checks++; if (out_carry !== 1'b1) $display("[TB] FAIL sub_zero_carry: got %b want 1", out_carry); else passed++;
        checks++; if (out_ovf !== 1'b0) $display("[TB] FAIL sub_zero_ovf: got %b want 0", out_ovf); else passed++;
        @(posedge clk); #1;
        send(4'd1, 1'b1, 1'b1);
        checks++; if (out_data !== 4'hF) $display("[TB] FAIL sub_one_data: got %h want f", out_data); else passed++;
        checks++; if (out_carry !== 1'b0) $display("[TB] FAIL sub_one_carry: got %b want 0", out_carry); else passed++;
        checks++; if (out_ovf !== 1'b0) $display("[TB] FAIL sub_one_ovf: got %b want 0", out_ovf); else passed++;
        checks++; if (out_count !== 4'd1) $display("[TB] FAIL sub_one_count: got %0d want 1", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(4'd2, 1'b0, 1'b0);
        send(4'd3, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'd7;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else passed++;
            checks++; if (out_data !== 4'd5) $display("[TB] FAIL bp_data[%0d]: got %h want 5", i, out_data); else passed++;
            checks++; if (out_count !== 4'd2) $display("[TB] FAIL bp_count[%0d]: got %0d want 2", i, out_count); else passed++;
            checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready[%0d]: got %b want 0", i, in_ready); else passed++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_data !== 4'd5) $display("[TB] FAIL bp_release_hold: got %h want 5", out_data); else passed++;
    endtask

    task automatic test_clear();
        send(4'd6, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL clr_ready: got %b want 0", in_ready); else passed++;
        @(posedge clk); #1;
        clr = 1'b0;
        send(4'd2, 1'b0, 1'b1);
        checks++; if (out_data !== 4'd2) $display("[TB] FAIL clr_data: got %h want 2", out_data); else passed++;
        checks++; if (out_count !== 4'd1) $display("[TB] FAIL clr_count: got %0d want 1", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        send(4'd4, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b want 0", out_valid); else passed++;
        send(4'd1, 1'b0, 1'b1);
        checks++; if (out_data !== 4'd1) $display("[TB] FAIL rst_mid_data: got %h want 1", out_data); else passed++;
        checks++; if (out_count !== 4'd1) $display("[TB] FAIL rst_mid_count: got %0d want 1", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    // Sixteen +1 beats: count saturates at 15, acc wraps to 0 with carry
    task automatic test_count_sat();
        for (int i = 0; i < 16; i++)
            send(4'd1, 1'b0, (i == 15));
        checks++; if (out_count !== 4'd15) $display("[TB] FAIL sat_count: got %0d want 15", out_count); else passed++;
        checks++; if (out_data !== 4'h0) $display("[TB] FAIL sat_data: got %h want 0", out_data); else passed++;
        checks++; if (out_zero !== 1'b1) $display("[TB] FAIL sat_zero: got %b want 1", out_zero); else passed++;
        checks++; if (out_carry !== 1'b1) $display("[TB] FAIL sat_carry: got %b want 1", out_carry); else passed++;
        checks++; if (out_ovf !== 1'b1) $display("[TB] FAIL sat_ovf: got %b want 1", out_ovf); else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_backpressure();
        test_clear();
        test_rst_mid();
        test_count_sat();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
